// File: rtl/lsu_pkg.sv
// LSU shared definitions: RV32I load/store funct3 codes, FSM states
// and request-side helpers (alignment check, byte strobes, lane fill).
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  // Unsupported widths are reported as misaligned.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic m;
    m = 1'b1;
    case (f3)
      F3_B, F3_BU: m = 1'b0;
      F3_H, F3_HU: m = a[0];
      F3_W:        m = |a;
      default:     m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] st_mask(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b0000;
    case (f3[1:0])
      2'd0:    m = 4'b0001 << a;
      2'd1:    m = 4'b0011 << a;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] st_data(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = d;
    case (f3[1:0])
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load lane select and sign/zero extension (combinational).
// Ports: i_funct3, i_lane (addr[1:0]), i_rdata (word) -> o_data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [31:0] w_sh;

  assign w_sh = i_rdata >> {i_lane, 3'b000};

  always_comb begin
    o_data = 32'd0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_BU:   o_data = {24'd0, w_sh[7:0]};
      F3_H:    o_data = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_HU:   o_data = {16'd0, w_sh[15:0]};
      F3_W:    o_data = i_rdata;
      default: o_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, word-aligned memory port,
// response timeout. Ports: req_* (execute), resp_* (writeback), mem_*.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  r_state;
  logic [2:0]  r_f3;
  logic        r_we;
  logic [1:0]  r_lane;
  logic [7:0]  r_cnt;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_mreq;
  logic [31:0] r_maddr;
  logic        r_mwen;
  logic [31:0] r_mwdata;
  logic [3:0]  r_mwmask;
  logic [31:0] w_ld;

  lsu_align u_align (
    .i_funct3 (r_f3),
    .i_lane   (r_lane),
    .i_rdata  (mem_rdata),
    .o_data   (w_ld)
  );

  // Gated by rst_n so ready stays low while reset is held.
  assign req_ready     = rst_n && (r_state == S_IDLE);
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign mem_req_valid = r_mreq;
  assign mem_addr      = r_maddr;
  assign mem_wen       = r_mwen;
  assign mem_wdata     = r_mwdata;
  assign mem_wmask     = r_mwmask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_f3         <= 3'd0;
      r_we         <= 1'b0;
      r_lane       <= 2'd0;
      r_cnt        <= 8'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_mreq       <= 1'b0;
      r_maddr      <= 32'd0;
      r_mwen       <= 1'b0;
      r_mwdata     <= 32'd0;
      r_mwmask     <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_f3   <= req_funct3;
            r_we   <= req_we;
            r_lane <= req_addr[1:0];
            r_cnt  <= 8'd0;
            if (misaligned(req_funct3, req_addr[1:0])) begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_state  <= S_REQ;
              r_mreq   <= 1'b1;
              r_maddr  <= {req_addr[31:2], 2'b00};
              r_mwen   <= req_we;
              r_mwdata <= st_data(req_funct3, req_wdata);
              r_mwmask <= req_we ?
                          st_mask(req_funct3, req_addr[1:0]) :
                          4'b0000;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_mreq  <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response wins over a coincident timeout.
          if (mem_resp_valid) begin
            r_state      <= S_DONE;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_we ? 32'd0 : w_ld;
          end else if (r_cnt == LP_LAST) begin
            r_state      <= S_DONE;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_resp_valid <= 1'b0;
          r_cnt        <= 8'd0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random
// transactions against a behavioural memory/response model.
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_rdy"},   req_ready, 0);
    chk({tag, "_rv"},    resp_valid, 0);
    chk({tag, "_rd"},    resp_rdata, 0);
    chk({tag, "_re"},    resp_err, 0);
    chk({tag, "_mv"},    mem_req_valid, 0);
    chk({tag, "_ma"},    mem_addr, 0);
    chk({tag, "_mwen"},  mem_wen, 0);
    chk({tag, "_mwd"},   mem_wdata, 0);
    chk({tag, "_mwm"},   mem_wmask, 0);
  endtask

  // rdy_dly: REQ cycles before mem_req_ready; rsp_dly: WAIT cycles
  // before mem_resp_valid (>= TO means the memory never answers).
  task automatic txn(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int rdy_dly,
                     input int rsp_dly, input logic junk);
    int          c0, nb, kexp, j;
    logic        mis, done, tmo;
    logic [31:0] ea, ewd, erd, sh;
    logic [3:0]  em;
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis = (f3 == 3 || f3 == 6 || f3 == 7) || (a % nb != 0);
    ea  = a & ~32'd3;
    em  = 4'd0;
    if (we) em = (nb == 4) ? 4'hF : 4'((((1 << nb) - 1) << (a % 4)));
    ewd = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
    sh  = rd >> (8 * (a % 4));
    case (f3)
      3'd0:    erd = {{24{sh[7]}}, sh[7:0]};
      3'd4:    erd = {24'd0, sh[7:0]};
      3'd1:    erd = {{16{sh[15]}}, sh[15:0]};
      3'd5:    erd = {16'd0, sh[15:0]};
      default: erd = rd;
    endcase
    tmo = (rsp_dly >= TO);
    if (we || tmo) erd = 32'd0;
    kexp = tmo ? TO : rsp_dly + 1;

    @(negedge clk);
    chk("accept_ready", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    c0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    if (mis) begin
      chk("mis_rv", resp_valid, 1);
      chk("mis_err", resp_err, 1);
      chk("mis_rd", resp_rdata, 0);
      chk("mis_nomem", mem_req_valid, 0);
      chk("mis_lat", cyc - c0, 1);
      erd = 32'd0;
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        if (i > 0) @(negedge clk);
        chk("req_ready_busy", req_ready, 0);
        chk("mreq_valid", mem_req_valid, 1);
        chk("mreq_addr", mem_addr, ea);
        chk("mreq_wen", mem_wen, we);
        chk("mreq_wdata", mem_wdata, ewd);
        chk("mreq_wmask", mem_wmask, em);
        mem_req_ready = (i == rdy_dly);
        mem_resp_valid = junk && (i < rdy_dly);
        mem_rdata = $urandom;
      end
      done = 1'b0;
      j = 0;
      while (!done && j <= 20) begin
        @(negedge clk);
        mem_req_ready = 1'b0;
        if (resp_valid) begin
          done = 1'b1;
          mem_resp_valid = 1'b0;
        end else begin
          mem_resp_valid = (j == rsp_dly);
          mem_rdata = (j == rsp_dly) ? rd : $urandom;
          j++;
        end
      end
      chk("resp_seen", done, 1);
      chk("resp_lat", cyc - c0, rdy_dly + 2 + kexp);
      chk("resp_err", resp_err, tmo);
      chk("resp_rdata", resp_rdata, erd);
    end
    @(negedge clk);
    mem_rdata = $urandom;
    chk("pulse_end", resp_valid, 0);
    chk("back_ready", req_ready, 1);
    chk("rdata_hold", resp_rdata, erd);
  endtask

  initial begin
    logic [2:0] st_f3 [6];
    logic [2:0] f3;
    logic       we;
    st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

    #1 rst_n = 1'b0;
    #1 chk_idle_outs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    txn(0, 3'd2, 32'h8000_0004, 0, 32'hDEAD_BEEF, 0, 0, 0);
    txn(0, 3'd0, 32'h8000_0003, 0, 32'h80FF_FFFF, 0, 0, 0);
    txn(0, 3'd4, 32'h8000_0003, 0, 32'h80FF_FFFF, 1, 1, 1);
    txn(0, 3'd5, 32'h8000_0002, 0, 32'h80FF_FFFF, 0, 2, 0);
    txn(1, 3'd1, 32'h1000_0002, 32'h1234_ABCD, 0, 0, 0, 0);
    txn(0, 3'd2, 32'h8000_0002, 0, 0, 0, 0, 0);
    txn(0, 3'd2, 32'h8000_0010, 0, 32'h1111_2222, 0, 100, 0);
    txn(0, 3'd1, 32'h8000_0012, 0, 32'h9876_5432, 2, TO - 1, 1);
    txn(1, 3'd3, 32'h8000_0000, 32'h55, 0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom % 2);
      f3 = we ? st_f3[$urandom % 6] : 3'($urandom % 8);
      txn(we, f3, $urandom, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, TO + 1),
          1'($urandom % 2));
    end

    // Reset while waiting for a memory response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h0000_0100;
    @(negedge clk);
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_outs("rst_wait");
    @(negedge clk);
    #2 rst_n = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("rst_wait_ready", req_ready, 1);
    chk("rst_wait_mv", mem_req_valid, 0);
    chk("rst_wait_norsp", resp_valid, 0);

    // Reset while the memory request is still outstanding.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h0000_0200; req_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_req_mv_pre", mem_req_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk_idle_outs("rst_req");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_req_mv", mem_req_valid, 0);

    txn(0, 3'd2, 32'h8000_0004, 0, 32'hDEAD_BEEF, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
